// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
// risc_pkg : shared constants for the RISC pipeline (ALU opcodes, fwd selects)
// Revision : 1.0
// ============================================================================
package risc_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int REG_AW_DEF = 3;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SLT   = 4'd7;
    localparam logic [3:0] OP_MUL   = 4'd8;
    localparam logic [3:0] OP_PASSB = 4'd9;

    localparam logic [1:0] ALU_SRC_REG   = 2'b00;
    localparam logic [1:0] ALU_SRC_EXMEM = 2'b10;
    localparam logic [1:0] ALU_SRC_MEMWB = 2'b01;

    function automatic logic is_mul(input logic [3:0] op);
        return op == OP_MUL;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_multiplier.sv
`default_nettype none
// ============================================================================
// ex_multiplier : sequential shift-add multiplier, one step per cycle
// Revision      : 1.0
// ============================================================================
module ex_multiplier #(
    parameter int DATA_W = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              done_o,
    output logic [DATA_W-1:0] product_o
);

    localparam int CW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] mcand_q, mplier_q, acc_q;
    logic [CW-1:0]     cnt_q;
    logic              run_q;

    // done_o marks the cycle performing the final step; product_o is valid after it
    assign done_o    = run_q && (cnt_q == CW'(DATA_W - 1));
    assign product_o = acc_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (abort_i) begin
            run_q <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= a_i;
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b1;
        end else if (run_q) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (done_o) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// ex_stage : execute stage (forwarding muxes, ALU, multi-cycle MUL) + EX/MEM reg
// Revision : 1.0
// ============================================================================
module ex_stage
    import risc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Idex_valid,
    input  logic [DATA_W-1:0] Idex_rs_data,
    input  logic [DATA_W-1:0] Idex_rt_data,
    input  logic [DATA_W-1:0] Idex_imm,
    input  logic [3:0]        Idex_alu_op,
    input  logic              Idex_b_imm,
    input  logic [REG_AW-1:0] Idex_rd,
    input  logic              Idex_reg_write,
    input  logic              Idex_mem_read,
    input  logic              Idex_mem_write,
    input  logic [1:0]        Alu_src1,
    input  logic [1:0]        Alu_src2,
    input  logic [DATA_W-1:0] Memwb_fwd_data,
    input  logic              Mem_stall,
    input  logic              Flush,
    output logic [DATA_W-1:0] Exmem_alu_result,
    output logic [DATA_W-1:0] Exmem_store_data,
    output logic [REG_AW-1:0] Exmem_rd,
    output logic              Exmem_reg_write,
    output logic              Exmem_mem_read,
    output logic              Exmem_mem_write,
    output logic              Exmem_valid,
    output logic              Exmem_zero,
    output logic              Ex_busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] op_a, rt_fwd, op_b, alu_res, mul_product;
    logic              mul_accept, mul_done;

    logic [DATA_W-1:0] res_q, res_d, sd_q, sd_d, msd_q;
    logic [REG_AW-1:0] rd_q, rd_d, mrd_q;
    logic              rw_q, rw_d, mr_q, mr_d, mw_q, mw_d, v_q, v_d, z_q, z_d;
    logic              mrw_q, mmr_q, mmw_q;

    always_comb begin
        case (Alu_src1)
            ALU_SRC_EXMEM: op_a = res_q;
            ALU_SRC_MEMWB: op_a = Memwb_fwd_data;
            default:       op_a = Idex_rs_data;
        endcase
        case (Alu_src2)
            ALU_SRC_EXMEM: rt_fwd = res_q;
            ALU_SRC_MEMWB: rt_fwd = Memwb_fwd_data;
            default:       rt_fwd = Idex_rt_data;
        endcase
        op_b = Idex_b_imm ? Idex_imm : rt_fwd;
    end

    always_comb begin
        alu_res = '0;
        case (Idex_alu_op)
            OP_ADD:   alu_res = op_a + op_b;
            OP_SUB:   alu_res = op_a - op_b;
            OP_AND:   alu_res = op_a & op_b;
            OP_OR:    alu_res = op_a | op_b;
            OP_XOR:   alu_res = op_a ^ op_b;
            OP_SLL:   alu_res = op_a << op_b[3:0];
            OP_SRL:   alu_res = op_a >> op_b[3:0];
            OP_SLT:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_PASSB: alu_res = op_b;
            default:  alu_res = '0;
        endcase
    end

    assign mul_accept = (state_q == S_IDLE) && Idex_valid && is_mul(Idex_alu_op) && !Flush;
    assign Ex_busy    = mul_accept || (state_q == S_MUL);

    ex_multiplier #(.DATA_W(DATA_W)) u_mult (
        .Clk       (Clk),
        .Rst       (Rst),
        .start_i   (mul_accept),
        .abort_i   (Flush),
        .a_i       (op_a),
        .b_i       (op_b),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_comb begin
        state_d = state_q;
        if (Flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (mul_accept) state_d = S_MUL;
                S_MUL:   if (mul_done)   state_d = S_DONE;
                S_DONE:  if (!Mem_stall) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Bubbles clear only control bits; the datapath keeps its last value
    always_comb begin
        res_d = res_q; sd_d = sd_q; rd_d = rd_q; z_d = z_q;
        rw_d  = rw_q;  mr_d = mr_q; mw_d = mw_q; v_d = v_q;
        if (!Mem_stall) begin
            rw_d = 1'b0; mr_d = 1'b0; mw_d = 1'b0; v_d = 1'b0;
            if (!Flush && state_q == S_DONE) begin
                res_d = mul_product; sd_d = msd_q; rd_d = mrd_q;
                rw_d  = mrw_q; mr_d = mmr_q; mw_d = mmw_q; v_d = 1'b1;
                z_d   = (mul_product == '0);
            end else if (!Flush && state_q == S_IDLE && Idex_valid && !is_mul(Idex_alu_op)) begin
                res_d = alu_res; sd_d = rt_fwd; rd_d = Idex_rd;
                rw_d  = Idex_reg_write; mr_d = Idex_mem_read; mw_d = Idex_mem_write;
                v_d   = 1'b1;
                z_d   = (alu_res == '0);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            res_q <= '0; sd_q <= '0; rd_q <= '0; z_q <= 1'b0;
            rw_q  <= 1'b0; mr_q <= 1'b0; mw_q <= 1'b0; v_q <= 1'b0;
            msd_q <= '0; mrd_q <= '0; mrw_q <= 1'b0; mmr_q <= 1'b0; mmw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q <= res_d; sd_q <= sd_d; rd_q <= rd_d; z_q <= z_d;
            rw_q  <= rw_d;  mr_q <= mr_d; mw_q <= mw_d; v_q <= v_d;
            if (mul_accept) begin
                msd_q <= rt_fwd; mrd_q <= Idex_rd;
                mrw_q <= Idex_reg_write; mmr_q <= Idex_mem_read; mmw_q <= Idex_mem_write;
            end
        end
    end

    assign Exmem_alu_result = res_q;
    assign Exmem_store_data = sd_q;
    assign Exmem_rd         = rd_q;
    assign Exmem_reg_write  = rw_q;
    assign Exmem_mem_read   = mr_q;
    assign Exmem_mem_write  = mw_q;
    assign Exmem_valid      = v_q;
    assign Exmem_zero       = z_q;

endmodule
`default_nettype wire
